// File: rtl/acs_sequencer.sv
// rtl/acs_sequencer.sv - ACS sweep sequencer for the Viterbi decoder
// Purpose: buffers received symbols in a small FIFO and, for each symbol,
//          sweeps ACSSegment over every segment of the trellis, pulsing
//          StepDone per completed step and requesting traceback every
//          TB_INTERVAL steps (parking while the traceback unit is busy).
// Ports:
//   Clock2, Reset            system clock, asynchronous active-low reset
//   Clear                    synchronous trellis restart (pulses MetricInit)
//   InValid, InCode, InReady symbol input handshake into the FIFO
//   Code                     symbol presented to the branch metric generator
//   ACSSegment, ACSEnable    segment index and live-sweep qualifier
//   StepDone, StepCount      step completion pulse and completed-step count
//   MetricInit               path metric reinitialise pulse
//   TBStart, TBBusy          traceback request and traceback busy
module acs_sequencer #(
  parameter int WD_FSM      = 6,
  parameter int WD_CODE     = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TB_INTERVAL = 16,
  parameter int WD_CNT      = 16
) (
  input  logic               Clock2,
  input  logic               Reset,
  input  logic               Clear,
  input  logic               InValid,
  input  logic [WD_CODE-1:0] InCode,
  output logic               InReady,
  output logic [WD_CODE-1:0] Code,
  output logic [WD_FSM-1:0]  ACSSegment,
  output logic               ACSEnable,
  output logic               StepDone,
  output logic               MetricInit,
  output logic               TBStart,
  input  logic               TBBusy,
  output logic [WD_CNT-1:0]  StepCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [WD_FSM-1:0] SEG_LAST = '1;
  localparam logic [WD_FSM-1:0] SEG_PRE  = {{(WD_FSM-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, WAIT_TB} state_t;

  state_t state, state_next;

  logic [WD_CODE-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               fifo_empty, wr, pop;

  // Set when the next symbol was already latched into Code during the
  // current sweep, so the following sweep can start without a LOAD cycle.
  logic               code_pending, pending_d;
  logic [WD_CODE-1:0] code_d;
  logic [WD_FSM-1:0]  seg_d;
  logic               en_d, step_done_d, tb_start_d, metric_init_d;
  logic [WD_CNT-1:0]  step_count_d, cnt_inc;
  logic               seg_last, seg_pre, interval_hit;

  assign InReady      = (count != FULL_CNT);
  assign fifo_empty   = (count == '0);
  assign wr           = InValid && InReady && !Clear;
  assign seg_last     = (ACSSegment == SEG_LAST);
  assign seg_pre      = (ACSSegment == SEG_PRE);
  assign cnt_inc      = StepCount + WD_CNT'(1);
  assign interval_hit = ((cnt_inc % WD_CNT'(TB_INTERVAL)) == '0);

  // Next-state logic
  always_comb begin
    state_next = state;
    if (Clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (!fifo_empty) state_next = LOAD;
        LOAD:    state_next = SWEEP;
        SWEEP: begin
          if (seg_last) begin
            if (interval_hit && TBBusy) state_next = WAIT_TB;
            else if (!code_pending)     state_next = IDLE;
          end
        end
        WAIT_TB: if (!TBBusy) state_next = code_pending ? SWEEP : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    pop           = 1'b0;
    code_d        = Code;
    seg_d         = ACSSegment;
    en_d          = ACSEnable;
    pending_d     = code_pending;
    step_count_d  = StepCount;
    step_done_d   = 1'b0;
    tb_start_d    = 1'b0;
    metric_init_d = 1'b0;
    if (Clear) begin
      seg_d         = SEG_LAST;
      en_d          = 1'b0;
      pending_d     = 1'b0;
      step_count_d  = '0;
      metric_init_d = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop    = 1'b1;
            code_d = mem[rd_ptr];
          end
        end
        LOAD: begin
          seg_d = '0;
          en_d  = 1'b1;
        end
        SWEEP: begin
          seg_d = ACSSegment + WD_FSM'(1);
          // Re-latch Code one cycle early: the branch metric generator
          // samples it on the edge where the segment is parked at the end.
          if (seg_pre && !fifo_empty) begin
            pop       = 1'b1;
            code_d    = mem[rd_ptr];
            pending_d = 1'b1;
          end
          if (seg_last) begin
            step_done_d  = 1'b1;
            step_count_d = cnt_inc;
            if (interval_hit && TBBusy) begin
              seg_d = SEG_LAST;
              en_d  = 1'b0;
            end else begin
              tb_start_d = interval_hit;
              if (code_pending) begin
                seg_d     = '0;
                pending_d = 1'b0;
              end else begin
                seg_d = SEG_LAST;
                en_d  = 1'b0;
              end
            end
          end
        end
        WAIT_TB: begin
          if (!TBBusy) begin
            tb_start_d = 1'b1;
            if (code_pending) begin
              seg_d     = '0;
              en_d      = 1'b1;
              pending_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clock2 or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      code_pending <= 1'b0;
      Code         <= '0;
      ACSSegment   <= SEG_LAST;
      ACSEnable    <= 1'b0;
      StepDone     <= 1'b0;
      MetricInit   <= 1'b0;
      TBStart      <= 1'b0;
      StepCount    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      state        <= state_next;
      code_pending <= pending_d;
      Code         <= code_d;
      ACSSegment   <= seg_d;
      ACSEnable    <= en_d;
      StepDone     <= step_done_d;
      MetricInit   <= metric_init_d;
      TBStart      <= tb_start_d;
      StepCount    <= step_count_d;
      if (Clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr)  wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({wr, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge Clock2) begin
    if (wr) mem[wr_ptr] <= InCode;
  end

endmodule

// File: tb/tb_acs_sequencer.sv
// tb/tb_acs_sequencer.sv - self-checking bench for acs_sequencer
module tb_acs_sequencer;

  logic       Clock2, Reset, Clear, InValid, TBBusy;
  logic [1:0] InCode;
  logic       InReady, ACSEnable, StepDone, MetricInit, TBStart;
  logic [1:0] Code;
  logic [5:0] ACSSegment;
  logic [15:0] StepCount;

  acs_sequencer #(
    .WD_FSM(6), .WD_CODE(2), .FIFO_DEPTH(4), .TB_INTERVAL(2), .WD_CNT(16)
  ) dut (
    .Clock2(Clock2), .Reset(Reset), .Clear(Clear), .InValid(InValid),
    .InCode(InCode), .InReady(InReady), .Code(Code), .ACSSegment(ACSSegment),
    .ACSEnable(ACSEnable), .StepDone(StepDone), .MetricInit(MetricInit),
    .TBStart(TBStart), .TBBusy(TBBusy), .StepCount(StepCount)
  );

  initial begin
    Clock2 = 1'b0;
    forever #5 Clock2 = ~Clock2;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       clr;
    logic       vld;
    logic [1:0] code_in;
    logic       rdy;
    logic [5:0] seg;
    logic       en;
    logic [1:0] code;
    logic       mi;
  } vec_t;

  vec_t vecs[5];

  int total = 0;
  int bad   = 0;

  // Expected order of symbols reaching segment 0 of a sweep.
  logic [1:0] exp_q[$];

  int         sd_cnt, tb_cnt, en_cycles, en_rises, seq_err;
  logic       prev_en, last_acc;
  logic [5:0] prev_seg;
  logic [1:0] prev_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_mon();
    sd_cnt = 0; tb_cnt = 0; en_cycles = 0; en_rises = 0; seq_err = 0;
    prev_en = ACSEnable; prev_seg = ACSSegment; prev_code = Code;
  endtask

  // One clock with the write model applied before the edge and the sweep
  // protocol observed #1 after it.
  task automatic tick_mon();
    logic [5:0] nxt;
    last_acc = 1'b0;
    if (Reset && Clear) exp_q.delete();
    else if (Reset && InValid && InReady) begin
      exp_q.push_back(InCode);
      last_acc = 1'b1;
    end
    @(posedge Clock2);
    #1;
    if (StepDone) sd_cnt++;
    if (TBStart)  tb_cnt++;
    if (ACSEnable) en_cycles++;
    nxt = prev_seg + 6'd1;
    if (ACSEnable && !prev_en) begin
      en_rises++;
      if (ACSSegment != 6'd0) seq_err++;
    end
    if (ACSEnable && prev_en && ACSSegment != nxt) seq_err++;
    if (!ACSEnable && ACSSegment != 6'd63) seq_err++;
    if (Code != prev_code && ACSSegment != 6'd63) seq_err++;
    if (ACSEnable && ACSSegment == 6'd0) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL seg0_code: sweep started with code %0d but no symbol expected", Code);
      end else begin
        chk("seg0_code", Code, exp_q.pop_front());
      end
    end
    prev_en = ACSEnable; prev_seg = ACSSegment; prev_code = Code;
  endtask

  task automatic wait_sd(input int n, input int limit, input string name);
    int i = 0;
    while (sd_cnt < n && i < limit) begin
      tick_mon();
      i++;
    end
    chk(name, sd_cnt, n);
  endtask

  task automatic wait_seg(input logic [5:0] seg, input int limit, input string name);
    int i = 0;
    while (!(ACSEnable && ACSSegment == seg) && i < limit) begin
      tick_mon();
      i++;
    end
    chk(name, {ACSEnable, ACSSegment}, {1'b1, seg});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_seg"},  ACSSegment, 6'd63);
    chk({tag, "_code"}, Code, 2'd0);
    chk({tag, "_en"},   ACSEnable, 1'b0);
    chk({tag, "_sd"},   StepDone, 1'b0);
    chk({tag, "_mi"},   MetricInit, 1'b0);
    chk({tag, "_tbs"},  TBStart, 1'b0);
    chk({tag, "_cnt"},  StepCount, 16'd0);
    chk({tag, "_rdy"},  InReady, 1'b1);
  endtask

  task automatic write_sym(input logic [1:0] s);
    InValid = 1'b1;
    InCode  = s;
    tick_mon();
    InValid = 1'b0;
  endtask

  logic [1:0] fill[5];
  int idx;

  initial begin
    //              clr   vld   in     rdy   seg    en    code   mi
    vecs[0] = '{1'b1, 1'b0, 2'd0, 1'b1, 6'd63, 1'b0, 2'd0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 2'd2, 1'b1, 6'd63, 1'b0, 2'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 2'd0, 1'b1, 6'd63, 1'b0, 2'd2, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 1'b1, 6'd0,  1'b1, 2'd2, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 1'b1, 6'd1,  1'b1, 2'd2, 1'b0};
    fill[0] = 2'b00; fill[1] = 2'b01; fill[2] = 2'b10; fill[3] = 2'b11; fill[4] = 2'b01;

    Reset = 1'b0; Clear = 1'b0; InValid = 1'b0; InCode = 2'b00; TBBusy = 1'b0;
    repeat (2) @(posedge Clock2);
    #3;
    check_reset_values("rst");
    @(posedge Clock2);
    #1;
    Reset = 1'b1;
    reset_mon();

    // Single symbol: table covers Clear, write, LOAD latency and sweep start.
    for (int i = 0; i < 5; i++) begin
      Clear   = vecs[i].clr;
      InValid = vecs[i].vld;
      InCode  = vecs[i].code_in;
      tick_mon();
      Clear   = 1'b0;
      InValid = 1'b0;
      chk($sformatf("v%0d_rdy", i),  InReady, vecs[i].rdy);
      chk($sformatf("v%0d_seg", i),  ACSSegment, vecs[i].seg);
      chk($sformatf("v%0d_en", i),   ACSEnable, vecs[i].en);
      chk($sformatf("v%0d_code", i), Code, vecs[i].code);
      chk($sformatf("v%0d_mi", i),   MetricInit, vecs[i].mi);
    end
    wait_sd(1, 100, "s1_stepdone");
    chk("s1_seg_park", ACSSegment, 6'd63);
    chk("s1_en_off", ACSEnable, 1'b0);
    chk("s1_count", StepCount, 16'd1);
    chk("s1_tbstart", TBStart, 1'b0);
    tick_mon();
    chk("s1_sd_pulse", StepDone, 1'b0);
    chk("s1_en_cycles", en_cycles, 64);
    chk("s1_rises", en_rises, 1);
    chk("s1_seq", seq_err, 0);

    // Three back-to-back symbols, restart with Clear first.
    Clear = 1'b1; tick_mon(); Clear = 1'b0;
    reset_mon();
    InValid = 1'b1;
    InCode = 2'b01; tick_mon();
    InCode = 2'b11; tick_mon();
    InCode = 2'b00; tick_mon();
    InValid = 1'b0;
    wait_sd(3, 400, "s2_stepdone");
    chk("s2_count", StepCount, 16'd3);
    chk("s2_tbstart", tb_cnt, 1);
    chk("s2_en_cycles", en_cycles, 192);
    chk("s2_rises", en_rises, 1);
    chk("s2_queue", exp_q.size(), 0);
    chk("s2_seq", seq_err, 0);
    tick_mon();
    chk("s2_idle_en", ACSEnable, 1'b0);

    // Traceback stall at step 2 with a pending symbol, then fill the FIFO.
    Clear = 1'b1; tick_mon(); Clear = 1'b0;
    reset_mon();
    TBBusy = 1'b1;
    write_sym(2'b10);
    write_sym(2'b01);
    write_sym(2'b11);
    wait_sd(2, 300, "s4_stepdone_b");
    chk("s4_wait_seg", ACSSegment, 6'd63);
    chk("s4_wait_en", ACSEnable, 1'b0);
    chk("s4_wait_tbs", TBStart, 1'b0);
    idx = 0;
    InValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      InCode = fill[idx];
      tick_mon();
      if (last_acc && idx < 4) idx++;
    end
    chk("s4_accepted", idx, 4);
    chk("s4_full_rdy", InReady, 1'b0);
    chk("s4_still_parked", {ACSEnable, ACSSegment}, {1'b0, 6'd63});
    InCode = fill[4];
    TBBusy = 1'b0;
    tick_mon();
    chk("s4_release_tbs", TBStart, 1'b1);
    chk("s4_release_seg", {ACSEnable, ACSSegment}, {1'b1, 6'd0});
    tick_mon();
    chk("s4_tbs_pulse", TBStart, 1'b0);
    for (int i = 0; i < 100 && !last_acc; i++) tick_mon();
    InValid = 1'b0;
    chk("s4_fifth_accept", {last_acc, ACSSegment}, {1'b1, 6'd0});
    wait_sd(8, 700, "s4_stepdone_all");
    chk("s4_count", StepCount, 16'd8);
    chk("s4_tb_pulses", tb_cnt, 4);
    chk("s4_rises", en_rises, 2);
    chk("s4_en_cycles", en_cycles, 512);
    chk("s4_queue", exp_q.size(), 0);
    chk("s4_seq", seq_err, 0);

    // Clear mid-sweep with two symbols queued; a coinciding write is dropped.
    reset_mon();
    InValid = 1'b1;
    InCode = 2'b11; tick_mon();
    InCode = 2'b00; tick_mon();
    InCode = 2'b10; tick_mon();
    InValid = 1'b0;
    wait_seg(6'd30, 100, "s5_reach30");
    Clear = 1'b1; InValid = 1'b1; InCode = 2'b01;
    tick_mon();
    Clear = 1'b0; InValid = 1'b0;
    chk("s5_mi", MetricInit, 1'b1);
    chk("s5_seg", ACSSegment, 6'd63);
    chk("s5_en", ACSEnable, 1'b0);
    chk("s5_count", StepCount, 16'd0);
    chk("s5_sd", StepDone, 1'b0);
    chk("s5_rdy", InReady, 1'b1);
    tick_mon();
    chk("s5_mi_pulse", MetricInit, 1'b0);
    reset_mon();
    repeat (100) tick_mon();
    chk("s5_no_stepdone", sd_cnt, 0);
    chk("s5_fifo_flushed", en_cycles, 0);

    // Asynchronous reset mid-sweep, then resume.
    write_sym(2'b11);
    wait_seg(6'd20, 100, "s6_reach20");
    #2;
    Reset = 1'b0;
    #1;
    check_reset_values("s6rst");
    reset_mon();
    repeat (3) tick_mon();
    chk("s6_no_sd", sd_cnt, 0);
    chk("s6_no_tbs", tb_cnt, 0);
    Reset = 1'b1;
    exp_q.delete();
    reset_mon();
    write_sym(2'b01);
    wait_sd(1, 200, "s6_resume_sd");
    chk("s6_count", StepCount, 16'd1);
    chk("s6_en_cycles", en_cycles, 64);
    chk("s6_seq", seq_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
